sseg_scan_driver: RTL and testbench

//  Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream
//  of the timer/counter core and upstream of the sseg/AN pins. It takes a frame of hex digits plus dp/blank masks

---
 rtl/sseg_scan_driver.sv | 249 ++++++++++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver
//   Time-multiplexed driver for a common-anode seven-segment display with up
//   to 8 digit slots. A frame (hex nibbles, decimal points, blank mask and a
//   leading-zero-blanking flag) is accepted over a valid/ready handshake into
//   a pending buffer and promoted to the active buffer only when the scan
//   wraps from the last slot back to slot 0, so a frame is never torn.
//
// Parameters
//   N_DIGITS     number of display slots (1..8)
//   SCAN_DIV     sysclk cycles per digit slot (>= 2)
//
// Ports
//   sysclk       system clock, rising edge
//   rst          asynchronous active-high reset
//   digits_i     hex nibble per slot, slot k = digits_i[4k+3:4k], slot 0 rightmost
//   dp_i         decimal point enable per slot (1 = lit)
//   blank_i      force slot dark (1 = blank)
//   lzb_i        leading-zero blanking enable
//   upd_valid    producer offers a new frame
//   upd_ready    pending buffer is empty, an offered frame will be taken
//   frame_start  one-cycle pulse while slot 0 is first shown
//   sseg         {dp,g,f,e,d,c,b,a}, active-low
//   AN           slot anodes, active-low, one-hot-low or all-high
// ---------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lzb_i,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    output logic                  frame_start,
    output logic [7:0]            sseg,
    output logic [N_DIGITS-1:0]   AN
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned NIB_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // One displayable frame as held in the pending and active buffers.
    typedef struct packed {
        logic [NIB_W-1:0]    digits;
        logic [N_DIGITS-1:0] dp;
        logic [N_DIGITS-1:0] blank;
        logic                lzb;
    } frame_t;

    // Pending-buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    logic [CNT_W-1:0]    cnt_q;
    logic                tick;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                wrap;

    buf_state_t          buf_q;
    buf_state_t          buf_d;
    logic                accept;
    logic                load_active;

    frame_t              in_frame;
    frame_t              pending_q;
    frame_t              active_q;
    frame_t              disp;

    logic                upper_zero;
    logic [N_DIGITS-1:0] slot_dark;
    logic [3:0]          sel_nib;
    logic                sel_dp;
    logic                sel_dark;
    logic [N_DIGITS-1:0] an_d;
    logic [7:0]          sseg_d;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Slot-rate prescaler.
    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Slot index; resets to the last slot so the first tick selects slot 0.
    assign wrap = tick && (idx_q == IDX_LAST);

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            idx_q <= IDX_LAST;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Pending-buffer state register.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            buf_q <= BUF_EMPTY;
        end else begin
            buf_q <= buf_d;
        end
    end

    // Pending-buffer next state: fill on handshake, drain on frame wrap.
    always_comb begin
        buf_d       = buf_q;
        accept      = 1'b0;
        load_active = 1'b0;
        case (buf_q)
            BUF_EMPTY: begin
                if (upd_valid) begin
                    accept = 1'b1;
                    buf_d  = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (wrap) begin
                    load_active = 1'b1;
                    buf_d       = BUF_EMPTY;
                end
            end
            default: buf_d = BUF_EMPTY;
        endcase
    end

    assign upd_ready = (buf_q == BUF_EMPTY);

    assign in_frame = '{digits: digits_i, dp: dp_i, blank: blank_i, lzb: lzb_i};

    // Frame buffers; reset leaves every slot blanked.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pending_q.digits <= '0;
            pending_q.dp     <= '0;
            pending_q.blank  <= '1;
            pending_q.lzb    <= 1'b0;
            active_q.digits  <= '0;
            active_q.dp      <= '0;
            active_q.blank   <= '1;
            active_q.lzb     <= 1'b0;
        end else begin
            if (accept) begin
                pending_q <= in_frame;
            end
            if (load_active) begin
                active_q <= pending_q;
            end
        end
    end

    // On the wrap that promotes a frame, slot 0 is decoded from the new data.
    assign disp = load_active ? pending_q : active_q;

    // Per-slot darkness: explicit blank, or a leading zero run reaching the top.
    always_comb begin
        slot_dark  = '0;
        upper_zero = 1'b1;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            upper_zero = 1'b1;
            for (int j = k; j < int'(N_DIGITS); j++) begin
                if (disp.digits[4*j +: 4] != 4'h0) begin
                    upper_zero = 1'b0;
                end
            end
            slot_dark[k] = disp.blank[k] | (disp.lzb & (k != 0) & upper_zero);
        end
    end

    // Fields of the slot about to be shown.
    always_comb begin
        sel_nib  = 4'h0;
        sel_dp   = 1'b0;
        sel_dark = 1'b1;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_nib  = disp.digits[4*k +: 4];
                sel_dp   = disp.dp[k];
                sel_dark = slot_dark[k];
            end
        end
    end

    assign an_d   = sel_dark ? '1 : ~(N_DIGITS'(1) << idx_d);
    assign sseg_d = sel_dark ? 8'hFF : {~sel_dp, hex_to_seg(sel_nib)};

    // Pin registers, updated only on the slot tick.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            AN          <= '1;
            sseg        <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (tick) begin
                AN   <= an_d;
                sseg <= sseg_d;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_driver
//   Self-checking bench for sseg_scan_driver (N_DIGITS=8, SCAN_DIV=4, 20 ns
//   clock). A frame-level reference model holds the shown frame and the queued
//   update; expected pin values are computed per slot from the display rules.
// ---------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int unsigned N   = 8;
    localparam int unsigned DIV = 4;
    localparam int SLOTS_CYC    = N * DIV;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        lzb;
    } frame_t;

    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        sysclk = 1'b0;
    logic        rst;
    logic [31:0] digits_i;
    logic [7:0]  dp_i;
    logic [7:0]  blank_i;
    logic        lzb_i;
    logic        upd_valid;
    logic        upd_ready;
    logic        frame_start;
    logic [7:0]  sseg;
    logic [7:0]  an;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    frame_t shown;
    frame_t queued;
    bit     qv;
    frame_t cur_in;

    sseg_scan_driver #(
        .N_DIGITS (N),
        .SCAN_DIV (DIV)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .digits_i    (digits_i),
        .dp_i        (dp_i),
        .blank_i     (blank_i),
        .lzb_i       (lzb_i),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .frame_start (frame_start),
        .sseg        (sseg),
        .AN          (an)
    );

    always #10 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t mk(input logic [31:0] d, input logic [7:0] p,
                                  input logic [7:0] b, input logic z);
        frame_t f;
        f.digits = d;
        f.dp     = p;
        f.blank  = b;
        f.lzb    = z;
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        int sh;
        sh       = int'($urandom_range(8, 0));
        f.digits = $urandom >> (4 * sh);
        f.dp     = 8'($urandom);
        f.blank  = 8'($urandom) & 8'($urandom) & 8'($urandom);
        f.lzb    = 1'($urandom);
        return f;
    endfunction

    function automatic bit exp_dark(input frame_t f, input int k);
        logic [31:0] upper;
        upper = f.digits >> (4 * k);
        return f.blank[k] || (f.lzb && k > 0 && upper == 32'h0);
    endfunction

    function automatic logic [7:0] exp_an(input frame_t f, input int k);
        logic [7:0] one;
        one = 8'h01;
        return exp_dark(f, k) ? 8'hFF : ~(one << k);
    endfunction

    function automatic logic [7:0] exp_sseg(input frame_t f, input int k);
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = f.digits >> (4 * k);
        nib = sh[3:0];
        if (exp_dark(f, k)) return 8'hFF;
        return SEG_LUT[nib] & (f.dp[k] ? 8'h7F : 8'hFF);
    endfunction

    task automatic drive_in(input bit v, input frame_t f);
        upd_valid = v;
        digits_i  = f.digits;
        dp_i      = f.dp;
        blank_i   = f.blank;
        lzb_i     = f.lzb;
        cur_in    = f;
    endtask

    task automatic model_reset();
        shown = mk(32'h0, 8'h00, 8'hFF, 1'b0);
        queued = shown;
        qv     = 1'b0;
    endtask

    // Entered at the negedge where slot 0 of a frame is first visible.
    // Optionally offers g at cycle offer_at and h on the following cycle.
    // Returns early at cycle stop_at (before checking it).
    task automatic run_frame(input int offer_at, input frame_t g, input bit second,
                             input frame_t h, input int stop_at);
        bit acc;
        int s;
        for (int t = 0; t < SLOTS_CYC; t++) begin
            if (t == stop_at) return;
            s = t / int'(DIV);
            check($sformatf("an s%0d c%0d", s, t % int'(DIV)), 32'(an), 32'(exp_an(shown, s)));
            check($sformatf("sseg s%0d c%0d", s, t % int'(DIV)), 32'(sseg), 32'(exp_sseg(shown, s)));
            check($sformatf("frame_start t%0d", t), 32'(frame_start), 32'(t == 0));
            check($sformatf("upd_ready t%0d", t), 32'(upd_ready), 32'(!qv));
            if (t == offer_at) drive_in(1'b1, g);
            else if (second && t == offer_at + 1) drive_in(1'b1, h);
            else drive_in(1'b0, rand_frame());
            // Effect of the coming rising edge on the model.
            acc = upd_valid && !qv;
            if (t == SLOTS_CYC - 1 && qv) begin
                shown = queued;
                qv    = 1'b0;
            end
            if (acc) begin
                queued = cur_in;
                qv     = 1'b1;
            end
            @(negedge sysclk);
        end
    endtask

    // Release reset at a negedge and time the first slot tick.
    task automatic after_release();
        int n;
        rst = 1'b0;
        n   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sysclk);
            n = i;
            if (frame_start) break;
            check($sformatf("dark_after_rst c%0d", i), 32'(an), 32'hFF);
        end
        check("first_tick_latency", 32'(n), 32'(DIV));
    endtask

    frame_t f2, f3, f4a, f4b, f6, junk;

    initial begin
        f2   = mk(32'h7654_3210, 8'h00, 8'h00, 1'b0);
        f3   = mk(32'h7654_3210, 8'h04, 8'h00, 1'b0);
        f4a  = mk(32'h0000_0050, 8'h00, 8'h00, 1'b1);
        f4b  = mk(32'h0000_0000, 8'h00, 8'h00, 1'b1);
        f6   = mk(32'h8888_8888, 8'h00, 8'hF0, 1'b0);
        junk = mk(32'hDEAD_BEEF, 8'hFF, 8'h00, 1'b0);

        rst = 1'b1;
        drive_in(1'b0, junk);
        model_reset();
        repeat (3) @(negedge sysclk);
        check("por_an", 32'(an), 32'hFF);
        check("por_sseg", 32'(sseg), 32'hFF);
        check("por_frame_start", 32'(frame_start), 32'h0);
        check("por_upd_ready", 32'(upd_ready), 32'h1);
        after_release();
        run_frame(-1, junk, 1'b0, junk, SLOTS_CYC);

        // Mid-scan reset with an update pending: pending must be discarded.
        run_frame(2, f2, 1'b0, junk, 9);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_an", 32'(an), 32'hFF);
        check("rst_sseg", 32'(sseg), 32'hFF);
        check("rst_upd_ready", 32'(upd_ready), 32'h1);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        @(negedge sysclk);
        @(negedge sysclk);
        after_release();
        run_frame(-1, junk, 1'b0, junk, SLOTS_CYC);

        // Directed frames, each offered one frame ahead of being shown.
        run_frame(6, f2, 1'b0, junk, SLOTS_CYC);
        run_frame(6, f3, 1'b0, junk, SLOTS_CYC);
        run_frame(6, f4a, 1'b0, junk, SLOTS_CYC);
        run_frame(6, f4b, 1'b0, junk, SLOTS_CYC);
        // Offer during slot 3 followed by a second offer that must be refused.
        run_frame(3 * int'(DIV) + 1, f6, 1'b1, junk, SLOTS_CYC);
        // Offer on the wrap-tick cycle: lands in pending, shows a frame later.
        run_frame(SLOTS_CYC - 1, f2, 1'b0, junk, SLOTS_CYC);
        run_frame(-1, junk, 1'b0, junk, SLOTS_CYC);

        // Randomized frames and offer positions.
        for (int i = 0; i < 10; i++) begin
            run_frame(int'($urandom_range(SLOTS_CYC - 1, 0)), rand_frame(),
                      1'($urandom), rand_frame(), SLOTS_CYC);
        end
        run_frame(-1, junk, 1'b0, junk, SLOTS_CYC);
        run_frame(-1, junk, 1'b0, junk, SLOTS_CYC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
